// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and default sizing for the FIFO write-port arbiter.
package fifo_arb_pkg;

  localparam int unsigned NUM_REQ_DEF    = 4;
  localparam int unsigned DATA_WIDTH_DEF = 128;
  localparam int unsigned MAX_BURST_DEF  = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  // Increment modulo n, for pointers where n need not be a power of two.
  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester bundle plus FIFO write port seen by the arbiter.
interface fifo_wr_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = NUM_REQ_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]                 req;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]                 ack;
  logic                               fifo_full;
  logic                               fifo_almost_full;
  logic                               fifo_wr_en;
  logic [DATA_WIDTH-1:0]              fifo_wr_data;
  logic [IDX_W-1:0]                   owner;
  logic                               busy;

  modport master (
    input  req, req_data, fifo_full, fifo_almost_full,
    output ack, fifo_wr_en, fifo_wr_data, owner, busy
  );

  modport slave (
    output req, req_data, fifo_full, fifo_almost_full,
    input  ack, fifo_wr_en, fifo_wr_data, owner, busy
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational round-robin search: first set request at or after ptr_i, wrapping.
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
  output logic [$clog2(NUM_REQ)-1:0] idx_o,
  output logic                       found_o
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CW    = IDX_W + 1;

  logic [CW-1:0] cand;

  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    cand    = '0;
    for (int unsigned ofs = 0; ofs < NUM_REQ; ofs++) begin
      cand = {1'b0, ptr_i} + CW'(ofs);
      if (cand >= CW'(NUM_REQ)) begin
        cand = cand - CW'(NUM_REQ);
      end
      if (!found_o && req_i[cand[IDX_W-1:0]]) begin
        found_o = 1'b1;
        idx_o   = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ requesters.
// Write strobe, data and ack are combinational from the registered grant state.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = NUM_REQ_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned MAX_BURST  = MAX_BURST_DEF
) (
  input  logic              clk,
  input  logic              rst,
  fifo_wr_arbiter_if.master bus
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;
  logic [CNT_W-1:0] cnt_inc;
  logic             wr_ok;
  logic             leave;

  rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req_i   (bus.req),
    .ptr_i   (rr_ptr_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign cnt_inc = burst_cnt_q + CNT_W'(1);

  always_comb begin
    state_d          = state_q;
    rr_ptr_d         = rr_ptr_q;
    owner_d          = owner_q;
    burst_cnt_d      = burst_cnt_q;
    wr_ok            = 1'b0;
    leave            = 1'b0;
    bus.ack          = '0;
    bus.fifo_wr_en   = 1'b0;
    bus.fifo_wr_data = DATA_WIDTH'(0);
    bus.owner        = owner_q;
    bus.busy         = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_found && !bus.fifo_full) begin
          owner_d     = pick_idx;
          burst_cnt_d = '0;
          state_d     = BURST;
        end
      end
      BURST: begin
        bus.busy = 1'b1;
        wr_ok    = bus.req[owner_q] && !bus.fifo_full;
        if (wr_ok) begin
          bus.ack[owner_q] = 1'b1;
          bus.fifo_wr_en   = 1'b1;
          bus.fifo_wr_data = bus.req_data[owner_q];
          burst_cnt_d      = cnt_inc;
          leave            = (cnt_inc == CNT_W'(MAX_BURST)) || bus.fifo_almost_full;
        end else if (!bus.req[owner_q]) begin
          leave = 1'b1;
        end
        // A full FIFO with the owner still requesting simply holds the burst.
        if (leave) begin
          state_d  = IDLE;
          rr_ptr_d = IDX_W'(wrap_inc(32'(owner_q), NUM_REQ));
        end
      end
      default: state_d = IDLE;
    endcase

    // Reset aborts a burst in the same cycle, so nothing may be written then.
    if (rst) begin
      bus.ack          = '0;
      bus.fifo_wr_en   = 1'b0;
      bus.fifo_wr_data = DATA_WIDTH'(0);
      bus.busy         = 1'b0;
    end
  end

  a_ack_onehot : assert property (@(posedge clk) $onehot0(bus.ack));
  a_wr_is_ack  : assert property (@(posedge clk) bus.fifo_wr_en == (|bus.ack));
  a_no_ovf     : assert property (@(posedge clk) !(bus.fifo_wr_en && bus.fifo_full));

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing the FIFO write port, 2..16.
REQ-002 Parameter DATA_WIDTH, default 128: word width, equal to the FIFO DATA_WIDTH.
REQ-003 Parameter MAX_BURST, default 4: maximum words per grant, 1..255.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req  input  NUM_REQ  per-requester write request, held until ack.
REQ-007 req_data  input  NUM_REQ x DATA_WIDTH  per-requester write word, stable while req is high.
REQ-008 ack  output  NUM_REQ  one-hot pulse: word of that requester written this cycle.
REQ-009 fifo_full  input  1  FIFO full flag.
REQ-010 fifo_almost_full  input  1  FIFO almost-full flag.
REQ-011 fifo_wr_en  output  1  FIFO write strobe.
REQ-012 fifo_wr_data  output  DATA_WIDTH  FIFO write word.
REQ-013 owner  output  $clog2(NUM_REQ)  index of current grant holder; valid when busy.
REQ-014 busy  output  1  high in BURST state.

Function
REQ-015 The FSM SHALL have two states: IDLE and BURST.
REQ-016 In IDLE, with any req high and fifo_full low, the arbiter SHALL select the first requester with req high at or after rr_ptr, wrapping modulo NUM_REQ, latch it as owner, clear burst_cnt and enter BURST next cycle.
REQ-017 In IDLE, no write and no ack SHALL occur; arbitration costs exactly one cycle.
REQ-018 In BURST, when req[owner]=1 and fifo_full=0, fifo_wr_en=1, fifo_wr_data=req_data[owner] and ack[owner]=1 in the same cycle (combinational from registered state); burst_cnt SHALL increment.
REQ-019 In BURST, when fifo_full=1, no write and no ack SHALL occur, and the state SHALL be held (stall).
REQ-020 BURST SHALL return to IDLE after the cycle in which any of the following holds: burst_cnt reaches MAX_BURST with this write; req[owner]=0; a write occurs while fifo_almost_full=1.
REQ-021 On leaving BURST, rr_ptr SHALL become (owner+1) mod NUM_REQ.
REQ-022 ack SHALL never have more than one bit set; fifo_wr_en SHALL equal OR of ack.
REQ-023 fifo_wr_en SHALL never be high while fifo_full is high.
REQ-024 Non-owner req inputs SHALL be ignored during BURST; requests are never dropped, only delayed.
REQ-025 fifo_wr_data SHALL be 0 when fifo_wr_en=0.
REQ-026 burst_cnt width SHALL be $clog2(MAX_BURST+1); no wrap-around within one burst.

Reset
REQ-027 While rst=1 at a clock edge: state=IDLE, rr_ptr=0, owner=0, burst_cnt=0.
REQ-028 During reset and in the first cycle after it: ack=0, fifo_wr_en=0, fifo_wr_data=0, busy=0.
REQ-029 Reset asserted mid-burst SHALL abort the burst without a write in the reset cycle; the interrupted requester re-arbitrates from rr_ptr=0.

Structure
REQ-030 Package fifo_arb_pkg SHALL hold the state enum (IDLE, BURST) and default parameter constants.
REQ-031 Sub-module rr_picker SHALL implement the combinational round-robin search (req vector, ptr -> index, found).
REQ-032 Only state, rr_ptr, owner and burst_cnt SHALL be registered.

Verification
REQ-033 Single requester: req[2]=1 with 3 words, FIFO empty -> one IDLE cycle, then 3 consecutive acks on bit 2, rr_ptr=3 afterwards.
REQ-034 All four req high continuously, MAX_BURST=4 -> grant order 0,1,2,3,0, each burst 4 writes, one idle cycle between bursts.
REQ-035 fifo_full forced high for 5 cycles mid-burst -> no wr_en or ack for 5 cycles, burst resumes with count preserved.
REQ-036 fifo_almost_full high at the second write of a burst -> exactly 2 writes, then IDLE and pointer advance.
REQ-037 rst pulsed high for 1 cycle during BURST with owner=1 -> outputs zero, next grant goes to the lowest requesting index from 0.
REQ-038 Integration with fifo (DEPTH=16, ALMOST_FULL=3), 4 random requesters, 200 words -> read-back data per requester in order, no overflow, no loss.
